hamming_enc_scheduler: RTL and testbench

Round-robin scheduler that shares one Hamming encoder engine among NUM_REQ requesters. It accepts one data word at a time over valid/ready handshakes and starts the engine. It waits for the engine to finish, with a watchdog timeout, then returns the codeword and the requester ID on a valid/ready output port. It sits between the per-channel framers and the single encoder instance in the ECC transmit path.

---
 rtl/hamming_enc_scheduler.sv | 157 +++++++++++++++
 tb/tb_hamming_enc_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_enc_scheduler.sv
// hamming_enc_scheduler
//
// Shares a single Hamming encoder engine among NUM_REQ requesters. One job at
// a time is accepted with a round-robin search, handed to the engine, waited
// on under a watchdog, and the codeword is returned with its requester ID.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   req_valid       per-requester request valid
//   req_data        packed words, requester i at [i*DATA_W +: DATA_W]
//   req_ready       one-hot acceptance pulse (IDLE grant cycle only)
//   eng_start       one-cycle engine start pulse
//   eng_data        word being encoded (latched at grant)
//   eng_done        engine completion pulse
//   eng_code        engine result, valid with eng_done
//   out_valid       codeword available (HOLD)
//   out_ready       consumer accepts
//   out_code        codeword
//   out_id          originating requester
//   err_timeout     one-cycle pulse when a job is aborted by the watchdog
//   err_id          requester of the last aborted job
//   grant_count     accepted requests, saturating at 16'hFFFF
module hamming_enc_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int CODE_W  = 12,
    parameter int TIMEOUT = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         eng_start,
    output logic [DATA_W-1:0]            eng_data,
    input  logic                         eng_done,
    input  logic [CODE_W-1:0]            eng_code,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CODE_W-1:0]            out_code,
    output logic [$clog2(NUM_REQ)-1:0]   out_id,
    output logic                         err_timeout,
    output logic [$clog2(NUM_REQ)-1:0]   err_id,
    output logic [15:0]                  grant_count
);

    localparam int ID_W = $clog2(NUM_REQ);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]                        state;
    logic [ID_W-1:0]                   rrPtr;
    logic [ID_W-1:0]                   jobId;
    logic [ID_W-1:0]                   errIdReg;
    logic [DATA_W-1:0]                 jobData;
    logic [CODE_W-1:0]                 outCode;
    logic [ID_W-1:0]                   outId;
    logic [7:0]                        waitCnt;
    logic [15:0]                       grantCount;

    logic [NUM_REQ-1:0][DATA_W-1:0]    reqWord;
    logic                              grantFound;
    logic [ID_W-1:0]                   grantId;
    logic [ID_W-1:0]                   nextPtr;
    logic [ID_W:0]                     cand;
    logic                              grantFire;
    logic                              timeoutHit;

    assign reqWord = req_data;

    // Round-robin search: first valid requester at or above rrPtr, wrapping.
    // cand is one bit wider so rrPtr+i never overflows before the wrap.
    always_comb begin
        grantFound = 1'b0;
        grantId    = '0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rrPtr} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ))
                cand = cand - (ID_W+1)'(NUM_REQ);
            if (!grantFound && req_valid[cand[ID_W-1:0]]) begin
                grantFound = 1'b1;
                grantId    = cand[ID_W-1:0];
            end
        end
    end

    assign nextPtr = (grantId == ID_W'(NUM_REQ-1)) ? '0 : grantId + ID_W'(1);

    // Gated by reset so nothing is accepted in a cycle whose state update
    // will be discarded.
    assign grantFire  = (state == IDLE) && grantFound && !reset;
    assign timeoutHit = (state == WAIT) && !eng_done && (waitCnt == 8'(TIMEOUT-1));

    assign req_ready   = grantFire ? (NUM_REQ'(1) << grantId) : '0;
    assign eng_start   = (state == ISSUE);
    assign eng_data    = jobData;
    assign out_valid   = (state == HOLD);
    assign out_code    = outCode;
    assign out_id      = outId;
    assign err_timeout = timeoutHit;
    // The aborting job's ID is visible in the pulse cycle itself, then held.
    assign err_id      = timeoutHit ? jobId : errIdReg;
    assign grant_count = grantCount;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rrPtr      <= '0;
            jobId      <= '0;
            errIdReg   <= '0;
            jobData    <= '0;
            outCode    <= '0;
            outId      <= '0;
            waitCnt    <= '0;
            grantCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantFound) begin
                        jobData <= reqWord[grantId];
                        jobId   <= grantId;
                        rrPtr   <= nextPtr;
                        if (grantCount != 16'hFFFF)
                            grantCount <= grantCount + 16'd1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    waitCnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    waitCnt <= waitCnt + 8'd1;
                    // eng_done takes precedence over an expiring watchdog.
                    if (eng_done) begin
                        outCode <= eng_code;
                        outId   <= jobId;
                        state   <= HOLD;
                    end else if (timeoutHit) begin
                        errIdReg <= jobId;
                        state    <= IDLE;
                    end
                end
                HOLD: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_enc_scheduler.sv
// Bench for hamming_enc_scheduler: engine model answering a programmable
// number of cycles after eng_start, scoreboard queues for expected grants and
// outputs, one task per scenario.
module tb_hamming_enc_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int CODE_W  = 12;
    localparam int TIMEOUT = 32;
    localparam int ID_W    = 2;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       eng_start;
    logic [DATA_W-1:0]          eng_data;
    logic                       eng_done;
    logic [CODE_W-1:0]          eng_code;
    logic                       out_valid;
    logic                       out_ready;
    logic [CODE_W-1:0]          out_code;
    logic [ID_W-1:0]            out_id;
    logic                       err_timeout;
    logic [ID_W-1:0]            err_id;
    logic [15:0]                grant_count;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [ID_W-1:0]   id;
    } outExp_t;

    int      expGrant[$];
    outExp_t expOut[$];
    int      errors   = 0;
    int      checks   = 0;
    int      engDelay = 1;   // 0 = engine never answers

    hamming_enc_scheduler #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CODE_W(CODE_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .eng_start(eng_start), .eng_data(eng_data),
        .eng_done(eng_done), .eng_code(eng_code),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .out_id(out_id),
        .err_timeout(err_timeout), .err_id(err_id),
        .grant_count(grant_count)
    );

    always #5 clk = ~clk;

    // Engine's encoding: word in the high bits, low nibble scrambled.
    function automatic logic [CODE_W-1:0] engModel(input logic [DATA_W-1:0] d);
        return {d, d[3:0] ^ 4'h9};
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Engine: eng_done in cycle S+engDelay for a start seen in cycle S.
    initial begin : engine
        int cnt;
        logic st;
        logic [DATA_W-1:0] w, pw;
        cnt = 0; pw = '0;
        eng_done = 1'b0; eng_code = '0;
        forever begin
            @(negedge clk);
            st = eng_start; w = eng_data;
            @(posedge clk); #1;
            eng_done = 1'b0;
            if (st === 1'b1 && engDelay > 0) begin cnt = engDelay; pw = w; end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin eng_done = 1'b1; eng_code = engModel(pw); end
            end
        end
    end

    // Scoreboard monitor: grants and output handshakes against queues.
    initial begin : monitor
        int e;
        outExp_t o;
        forever begin
            @(negedge clk);
            if (|req_ready === 1'b1) begin
                checks++;
                if (expGrant.size() == 0) begin
                    errors++;
                    $display("FAIL grant_order: req_ready=%b, no grant expected", req_ready);
                end else begin
                    e = expGrant.pop_front();
                    if (req_ready !== (NUM_REQ'(1) << e)) begin
                        errors++;
                        $display("FAIL grant_order: req_ready=%b, expected requester %0d", req_ready, e);
                    end
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (expOut.size() == 0) begin
                    errors++;
                    $display("FAIL output_order: code=%h id=%0d, no output expected", out_code, out_id);
                end else begin
                    o = expOut.pop_front();
                    if (out_code !== o.code || out_id !== o.id) begin
                        errors++;
                        $display("FAIL output_data: code=%h id=%0d, expected code=%h id=%0d",
                                 out_code, out_id, o.code, o.id);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; req_valid = '0; out_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL reset_eng_start: got %b want 0", eng_start); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err_timeout: got %b want 0", err_timeout); end
        checks++; if (out_code !== '0 || out_id !== '0) begin errors++; $display("FAIL reset_out: code=%h id=%0d want 0/0", out_code, out_id); end
        checks++; if (err_id !== '0) begin errors++; $display("FAIL reset_err_id: got %0d want 0", err_id); end
        checks++; if (eng_data !== '0) begin errors++; $display("FAIL reset_eng_data: got %h want 0", eng_data); end
        checks++; if (grant_count !== 16'd0) begin errors++; $display("FAIL reset_grant_count: got %0d want 0", grant_count); end
        step();
    endtask

    task automatic test_single();
        outExp_t o;
        engDelay = 2; out_ready = 1'b1;
        req_data = '0; req_data[2*DATA_W +: DATA_W] = 8'hA5; req_valid = 4'b0100;
        expGrant.push_back(2);
        o.code = 12'hA5C; o.id = 2'd2; expOut.push_back(o);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            case (c)
                0: begin
                    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", req_ready); end
                end
                1: begin
                    checks++; if (eng_start !== 1'b1 || eng_data !== 8'hA5) begin errors++; $display("FAIL single_start: start=%b data=%h want 1/a5", eng_start, eng_data); end
                end
                3: begin
                    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", out_valid); end
                end
                4: begin
                    checks++; if (out_valid !== 1'b1 || out_code !== 12'hA5C || out_id !== 2'd2) begin errors++; $display("FAIL single_out: valid=%b code=%h id=%0d want 1/a5c/2", out_valid, out_code, out_id); end
                    checks++; if (grant_count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d want 1", grant_count); end
                end
                default: ;
            endcase
            step();
            if (c == 0) req_valid = '0;
        end
    endtask

    task automatic test_back_to_back();
        outExp_t o;
        int nGrant, lastG;
        logic [DATA_W-1:0] d;
        nGrant = 0; lastG = -1;
        engDelay = 1; out_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = 8'h10 + 8'(i * 17);
        for (int k = 0; k < 5; k++) begin
            d = 8'h10 + 8'((k % 4) * 17);
            expGrant.push_back(k % 4);
            o.code = engModel(d); o.id = ID_W'(k % 4); expOut.push_back(o);
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (|req_ready === 1'b1) begin
                if (lastG >= 0) begin
                    checks++; if (c - lastG != 4) begin errors++; $display("FAIL b2b_spacing: got %0d cycles want 4", c - lastG); end
                end
                lastG = c; nGrant++;
            end
            step();
            if (nGrant == 5) req_valid = '0;
        end
        @(negedge clk);
        checks++; if (nGrant != 5) begin errors++; $display("FAIL b2b_grants: got %0d want 5", nGrant); end
        checks++; if (grant_count !== 16'd5) begin errors++; $display("FAIL b2b_count: got %0d want 5", grant_count); end
        checks++; if (expGrant.size() != 0 || expOut.size() != 0) begin errors++; $display("FAIL b2b_drain: pending grants=%0d outputs=%0d want 0/0", expGrant.size(), expOut.size()); end
        step();
    endtask

    task automatic test_wrap();
        outExp_t o;
        logic [NUM_REQ-1:0] g;
        engDelay = 1; out_ready = 1'b1;
        req_data[0 +: DATA_W] = 8'h31; req_data[DATA_W +: DATA_W] = 8'h42;
        expGrant.push_back(0); expGrant.push_back(1);
        o.code = engModel(8'h31); o.id = 2'd0; expOut.push_back(o);
        o.code = engModel(8'h42); o.id = 2'd1; expOut.push_back(o);
        req_valid = 4'b0011;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            g = req_ready;
            if (c == 0) begin
                checks++; if (g !== 4'b0001) begin errors++; $display("FAIL wrap_first: got %b want 0001", g); end
            end
            step();
            req_valid = req_valid & ~g;
        end
        checks++; if (expGrant.size() != 0 || expOut.size() != 0) begin errors++; $display("FAIL wrap_drain: pending grants=%0d outputs=%0d want 0/0", expGrant.size(), expOut.size()); end
    endtask

    task automatic test_timeout();
        outExp_t o;
        logic [NUM_REQ-1:0] g;
        int g1, g2, errC, nErr, earlyValid;
        g1 = -1; g2 = -1; errC = -1; nErr = 0; earlyValid = 0;
        engDelay = 0; out_ready = 1'b1;
        req_data[1*DATA_W +: DATA_W] = 8'h66; req_data[3*DATA_W +: DATA_W] = 8'h7E;
        expGrant.push_back(1); expGrant.push_back(3);
        o.code = engModel(8'h7E); o.id = 2'd3; expOut.push_back(o);
        req_valid = 4'b0010;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            g = req_ready;
            if (|g === 1'b1) begin
                if (g1 < 0) g1 = c; else if (g2 < 0) g2 = c;
            end
            if (err_timeout === 1'b1) begin
                nErr++; errC = c;
                checks++; if (err_id !== 2'd1) begin errors++; $display("FAIL timeout_err_id: got %0d want 1", err_id); end
            end
            if (out_valid === 1'b1 && g2 < 0) earlyValid++;
            step();
            if (|g === 1'b1) req_valid = (g == 4'b0010) ? 4'b1000 : 4'b0000;
            if (errC == c) engDelay = 1;
        end
        @(negedge clk);
        checks++; if (g1 != 0) begin errors++; $display("FAIL timeout_grant1: got cycle %0d want 0", g1); end
        checks++; if (nErr != 1) begin errors++; $display("FAIL timeout_pulses: got %0d want 1", nErr); end
        checks++; if (errC - g1 != 33) begin errors++; $display("FAIL timeout_latency: got %0d want 33", errC - g1); end
        checks++; if (g2 - g1 != 34) begin errors++; $display("FAIL timeout_next_grant: got %0d want 34", g2 - g1); end
        checks++; if (earlyValid != 0) begin errors++; $display("FAIL timeout_out_valid: got %0d valid cycles want 0", earlyValid); end
        checks++; if (err_id !== 2'd1) begin errors++; $display("FAIL timeout_err_id_held: got %0d want 1", err_id); end
        checks++; if (expOut.size() != 0) begin errors++; $display("FAIL timeout_drain: pending outputs=%0d want 0", expOut.size()); end
        step();
    endtask

    task automatic test_race();
        outExp_t o;
        logic [NUM_REQ-1:0] g;
        int nErr, vC;
        nErr = 0; vC = -1;
        engDelay = TIMEOUT; out_ready = 1'b1;
        req_data[0 +: DATA_W] = 8'hC3;
        expGrant.push_back(0);
        o.code = 12'hC3A; o.id = 2'd0; expOut.push_back(o);
        req_valid = 4'b0001;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            g = req_ready;
            if (err_timeout === 1'b1) nErr++;
            if (out_valid === 1'b1 && vC < 0) begin
                vC = c;
                checks++; if (out_code !== 12'hC3A) begin errors++; $display("FAIL race_code: got %h want c3a", out_code); end
            end
            step();
            req_valid = req_valid & ~g;
        end
        checks++; if (nErr != 0) begin errors++; $display("FAIL race_err_pulse: got %0d want 0", nErr); end
        checks++; if (vC != 34) begin errors++; $display("FAIL race_valid_cycle: got %0d want 34", vC); end
        checks++; if (err_id !== 2'd1) begin errors++; $display("FAIL race_err_id: got %0d want 1", err_id); end
        checks++; if (expOut.size() != 0) begin errors++; $display("FAIL race_drain: pending outputs=%0d want 0", expOut.size()); end
        engDelay = 1;
    endtask

    task automatic test_hold_reset();
        outExp_t o;
        engDelay = 1; out_ready = 1'b0;
        req_data[2*DATA_W +: DATA_W] = 8'h5A;
        expGrant.push_back(2);
        req_valid = 4'b0100;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL hold_grant: got %b want 0100", req_ready); end
            end
            if (c >= 3) begin
                checks++;
                if (out_valid !== 1'b1 || out_code !== 12'h5A3 || out_id !== 2'd2 || req_ready !== '0) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%b code=%h id=%0d ready=%b want 1/5a3/2/0000",
                             out_valid, out_code, out_id, req_ready);
                end
            end
            step();
            if (c == 0) req_valid = 4'b1011;
        end
        reset = 1'b1; req_valid = '0;
        step();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL hold_reset_valid: valid=%b err=%b want 0/0", out_valid, err_timeout); end
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_code !== '0 || out_id !== '0 || err_id !== '0 ||
            grant_count !== 16'd0 || eng_data !== '0 || eng_start !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL hold_reset_outputs: valid=%b code=%h id=%0d err_id=%0d count=%0d data=%h start=%b ready=%b want all 0",
                     out_valid, out_code, out_id, err_id, grant_count, eng_data, eng_start, req_ready);
        end
        step();
        out_ready = 1'b1;
        req_data[1*DATA_W +: DATA_W] = 8'h99; req_data[3*DATA_W +: DATA_W] = 8'h11;
        expGrant.push_back(1);
        o.code = engModel(8'h99); o.id = 2'd1; expOut.push_back(o);
        req_valid = 4'b1010;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL hold_after_reset_grant: got %b want 0010", req_ready); end
        step();
        req_valid = '0;
        for (int c = 0; c < 8; c++) step();
        checks++; if (expGrant.size() != 0 || expOut.size() != 0) begin errors++; $display("FAIL hold_drain: pending grants=%0d outputs=%0d want 0/0", expGrant.size(), expOut.size()); end
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_reset();
        test_single();
        test_wrap();
        test_timeout();
        test_race();
        test_hold_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation still running at 200000 time units, expected to finish earlier");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
